// File: rtl/dec2_4_pulse_if.sv
// Purpose: encoded request bus between an encoder-side master and dec2_4_pulse.
// Latency: none, signal bundle only.
// Backpressure: master offers Y with V; codes offered while ACCEPT=0 are dropped.
//
// Signals:
//   Y[1:0]  code to decode          (master -> slave)
//   V       code valid strobe       (master -> slave)
//   ACCEPT  FIFO not full           (slave -> master)
//   O[3:0]  one-hot pulse output    (slave -> master)
//   BUSY    pulse or gap in flight  (slave -> master)
//   CNT[2:0] FIFO occupancy 0..4    (slave -> master)
//   OVF     sticky overflow flag    (slave -> master)
interface dec2_4_pulse_if;
  logic [1:0] Y;
  logic       V;
  logic       ACCEPT;
  logic [3:0] O;
  logic       BUSY;
  logic [2:0] CNT;
  logic       OVF;

  modport master (
    output Y, V,
    input  ACCEPT, O, BUSY, CNT, OVF
  );

  modport slave (
    input  Y, V,
    output ACCEPT, O, BUSY, CNT, OVF
  );
endinterface

// File: rtl/dec2_4_pulse.sv
// Purpose: queue 2-bit codes and replay each as a one-hot pulse of HOLD_CYCLES cycles.
// Latency: code written at edge n into an empty idle block drives O after edge n+1.
// Backpressure: ACCEPT drops when the 4-entry FIFO is full; offered codes then set OVF.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    dec2_4_pulse_if slave: Y/V in; ACCEPT, O, BUSY, CNT, OVF out
// Parameters:
//   HOLD_CYCLES  cycles each pulse stays high, 1..15
module dec2_4_pulse #(
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic           clk,
  input  logic           reset,
  dec2_4_pulse_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // Hold counter reloads with HOLD_CYCLES-1 so the pulse stays up for the
  // load cycle plus HOLD_CYCLES-1 decrement cycles.
  localparam logic [3:0] HC_LOAD = 4'(HOLD_CYCLES - 1);

  // FIFO storage and bookkeeping
  logic [1:0] r_mem [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_cnt;
  logic       r_ovf;

  // Pulse sequencer
  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_hc;
  logic [3:0] w_hc_nxt;
  logic [3:0] r_o;
  logic [3:0] w_o_nxt;
  logic       w_pop;

  logic       w_accept;
  logic       w_wr;
  logic [1:0] w_head;
  logic [3:0] w_head_onehot;

  // ACCEPT looks only at the registered count, so a pop in the same cycle
  // does not open a slot for a code offered while full.
  assign w_accept      = (r_cnt != 3'd4);
  assign w_wr          = bus.V & w_accept;
  assign w_head        = r_mem[r_rptr];
  assign w_head_onehot = 4'b0001 << w_head;

  // Next-state / output logic. The FSM only sees registered occupancy, so a
  // code written into an empty FIFO is picked up one cycle later.
  always_comb begin
    w_state_nxt = r_state;
    w_hc_nxt    = r_hc;
    w_o_nxt     = r_o;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_o_nxt = 4'b0000;
        if (r_cnt != 3'd0) begin
          w_pop       = 1'b1;
          w_o_nxt     = w_head_onehot;
          w_hc_nxt    = HC_LOAD;
          w_state_nxt = S_DRIVE;
        end
      end

      S_DRIVE: begin
        if (r_hc != 4'd0) begin
          w_hc_nxt = r_hc - 4'd1;
        end else begin
          w_o_nxt     = 4'b0000;
          w_state_nxt = S_GAP;
        end
      end

      S_GAP: begin
        // Exactly one idle cycle between pulses: either reload here or park.
        if (r_cnt != 3'd0) begin
          w_pop       = 1'b1;
          w_o_nxt     = w_head_onehot;
          w_hc_nxt    = HC_LOAD;
          w_state_nxt = S_DRIVE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_o_nxt     = 4'b0000;
        w_hc_nxt    = 4'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hc    <= 4'd0;
      r_o     <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_hc    <= w_hc_nxt;
      r_o     <= w_o_nxt;
    end
  end

  // FIFO registers; simultaneous write and pop leave the count unchanged
  // while both pointers advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 2'b00;
      end
      r_wptr <= 2'd0;
      r_rptr <= 2'd0;
      r_cnt  <= 3'd0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= bus.Y;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (bus.V && !w_accept) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign bus.O      = r_o;
  assign bus.BUSY   = (r_state != S_IDLE);
  assign bus.CNT    = r_cnt;
  assign bus.ACCEPT = w_accept;
  assign bus.OVF    = r_ovf;

endmodule

// File: tb/tb_dec2_4_pulse.sv
// Bench for dec2_4_pulse: three instances (HOLD_CYCLES 2, 15, 1) on one clock.
// Directed stimulus; a per-instance queue of expected pulse codes is filled at
// issue time and drained by a negedge monitor that also checks pulse width.
module tb_dec2_4_pulse;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dec2_4_pulse_if if_h2 ();
  dec2_4_pulse_if if_h15 ();
  dec2_4_pulse_if if_h1 ();

  dec2_4_pulse #(.HOLD_CYCLES(2))  u_h2  (.clk(clk), .reset(rst), .bus(if_h2.slave));
  dec2_4_pulse #(.HOLD_CYCLES(15)) u_h15 (.clk(clk), .reset(rst), .bus(if_h15.slave));
  dec2_4_pulse #(.HOLD_CYCLES(1))  u_h1  (.clk(clk), .reset(rst), .bus(if_h1.slave));

  // Index 0 = HOLD 2, 1 = HOLD 15, 2 = HOLD 1
  int hold_a[3] = '{2, 15, 1};

  logic [3:0] o_a   [3];
  logic [2:0] cnt_a [3];
  logic       busy_a[3];
  logic       acc_a [3];
  logic       ovf_a [3];

  assign o_a[0] = if_h2.O;  assign cnt_a[0] = if_h2.CNT;  assign busy_a[0] = if_h2.BUSY;
  assign acc_a[0] = if_h2.ACCEPT;  assign ovf_a[0] = if_h2.OVF;
  assign o_a[1] = if_h15.O; assign cnt_a[1] = if_h15.CNT; assign busy_a[1] = if_h15.BUSY;
  assign acc_a[1] = if_h15.ACCEPT; assign ovf_a[1] = if_h15.OVF;
  assign o_a[2] = if_h1.O;  assign cnt_a[2] = if_h1.CNT;  assign busy_a[2] = if_h1.BUSY;
  assign acc_a[2] = if_h1.ACCEPT;  assign ovf_a[2] = if_h1.OVF;

  int errors = 0;
  int checks = 0;

  logic [3:0] exp_q [3][$];
  logic [3:0] prev_a  [3];
  int         width_a [3];
  int         pulses_a[3];

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic set_in(input int k, input logic [1:0] y, input logic v);
    case (k)
      0:       begin if_h2.Y  = y; if_h2.V  = v; end
      1:       begin if_h15.Y = y; if_h15.V = v; end
      default: begin if_h1.Y  = y; if_h1.V  = v; end
    endcase
  endtask

  // Offer a code that is expected to be accepted and later replayed.
  task automatic push_wr(input int k, input logic [1:0] y);
    logic [3:0] e;
    e = 4'b0001 << y;
    set_in(k, y, 1'b1);
    exp_q[k].push_back(e);
  endtask

  // Advance one edge, then compare O/BUSY/CNT against hand-computed values.
  task automatic step_chk(input int k, input string tag, input int eo, input int eb, input int ec);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s[%0d].O", tag, k),    int'(o_a[k]),    eo);
    chk($sformatf("%s[%0d].BUSY", tag, k), int'(busy_a[k]), eb);
    chk($sformatf("%s[%0d].CNT", tag, k),  int'(cnt_a[k]),  ec);
  endtask

  task automatic wait_idle(input int k, input int max_cyc);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || busy_a[k]) && n < max_cyc) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk($sformatf("idle_within_budget[%0d]", k), int'(n < max_cyc), 1);
  endtask

  task automatic mon_step(input int k);
    logic [3:0] o;
    logic [3:0] e;
    o = o_a[k];
    if (rst) begin
      exp_q[k].delete();
      width_a[k] = 0;
      prev_a[k]  = 4'b0000;
    end else begin
      if (prev_a[k] == 4'b0000 && o != 4'b0000) begin
        pulses_a[k]++;
        chk($sformatf("onehot[%0d]", k), $countones(o), 1);
        if (exp_q[k].size() == 0) begin
          chk($sformatf("unexpected_pulse[%0d]", k), int'(o), 0);
        end else begin
          e = exp_q[k].pop_front();
          chk($sformatf("pulse_code[%0d]", k), int'(o), int'(e));
        end
        width_a[k] = 1;
      end else if (prev_a[k] != 4'b0000 && o == prev_a[k]) begin
        width_a[k]++;
      end else if (prev_a[k] != 4'b0000 && o == 4'b0000) begin
        chk($sformatf("pulse_width[%0d]", k), width_a[k], hold_a[k]);
      end else if (prev_a[k] != 4'b0000) begin
        chk($sformatf("pulse_glitch[%0d]", k), int'(o), int'(prev_a[k]));
      end
      prev_a[k] = o;
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon_step(k);
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) set_in(k, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;

    // Reset state held over 10 idle cycles
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst_idle_O[%0d]", k),    int'(o_a[k]),    0);
        chk($sformatf("rst_idle_CNT[%0d]", k),  int'(cnt_a[k]),  0);
        chk($sformatf("rst_idle_ACC[%0d]", k),  int'(acc_a[k]),  1);
        chk($sformatf("rst_idle_BUSY[%0d]", k), int'(busy_a[k]), 0);
        chk($sformatf("rst_idle_OVF[%0d]", k),  int'(ovf_a[k]),  0);
      end
    end

    // Single code 2'b10 with HOLD 2
    push_wr(0, 2'b10);
    step_chk(0, "single", 0, 0, 1);
    set_in(0, 2'b00, 1'b0);
    step_chk(0, "single", 4, 1, 0);
    step_chk(0, "single", 4, 1, 0);
    step_chk(0, "single", 0, 1, 0);
    step_chk(0, "single", 0, 0, 0);

    // Burst 3,0,1,2: ordering, 2-high/1-low spacing, CNT peaks at 3
    push_wr(0, 2'd3); step_chk(0, "burst", 0, 0, 1);
    push_wr(0, 2'd0); step_chk(0, "burst", 8, 1, 1);
    push_wr(0, 2'd1); step_chk(0, "burst", 8, 1, 2);
    push_wr(0, 2'd2); step_chk(0, "burst", 0, 1, 3);
    set_in(0, 2'b00, 1'b0);
    step_chk(0, "burst", 1, 1, 2);
    step_chk(0, "burst", 1, 1, 2);
    step_chk(0, "burst", 0, 1, 2);
    step_chk(0, "burst", 2, 1, 1);
    step_chk(0, "burst", 2, 1, 1);
    step_chk(0, "burst", 0, 1, 1);
    step_chk(0, "burst", 4, 1, 0);
    step_chk(0, "burst", 4, 1, 0);
    step_chk(0, "burst", 0, 1, 0);
    step_chk(0, "burst", 0, 0, 0);

    // HOLD 1 boundary: codes 1,1 back-to-back
    push_wr(2, 2'd1); step_chk(2, "hold1", 0, 0, 1);
    push_wr(2, 2'd1); step_chk(2, "hold1", 2, 1, 1);
    set_in(2, 2'b00, 1'b0);
    step_chk(2, "hold1", 0, 1, 1);
    step_chk(2, "hold1", 2, 1, 0);
    step_chk(2, "hold1", 0, 1, 0);
    step_chk(2, "hold1", 0, 0, 0);

    // Overflow with HOLD 15: six back-to-back offers, five accepted
    push_wr(1, 2'd0); step_chk(1, "ovf", 0, 0, 1);
    push_wr(1, 2'd1); step_chk(1, "ovf", 1, 1, 1);
    push_wr(1, 2'd2); step_chk(1, "ovf", 1, 1, 2);
    push_wr(1, 2'd3); step_chk(1, "ovf", 1, 1, 3);
    push_wr(1, 2'd0); step_chk(1, "ovf", 1, 1, 4);
    chk("ovf_full_ACC", int'(acc_a[1]), 0);
    chk("ovf_before_OVF", int'(ovf_a[1]), 0);
    set_in(1, 2'd1, 1'b1);
    step_chk(1, "ovf", 1, 1, 4);
    chk("ovf_set_OVF", int'(ovf_a[1]), 1);
    chk("ovf_set_ACC", int'(acc_a[1]), 0);
    set_in(1, 2'b00, 1'b0);
    wait_idle(1, 150);
    chk("ovf_pulse_count", pulses_a[1], 5);
    chk("ovf_sticky_OVF", int'(ovf_a[1]), 1);
    chk("ovf_drain_ACC", int'(acc_a[1]), 1);

    // Reset mid-pulse with O=0010 and CNT=3
    push_wr(1, 2'd1); step_chk(1, "midrst", 0, 0, 1);
    push_wr(1, 2'd2); step_chk(1, "midrst", 2, 1, 1);
    push_wr(1, 2'd3); step_chk(1, "midrst", 2, 1, 2);
    push_wr(1, 2'd0); step_chk(1, "midrst", 2, 1, 3);
    set_in(1, 2'b00, 1'b0);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_O",    int'(o_a[1]),    0);
    chk("midrst_CNT",  int'(cnt_a[1]),  0);
    chk("midrst_BUSY", int'(busy_a[1]), 0);
    chk("midrst_ACC",  int'(acc_a[1]),  1);
    chk("midrst_OVF",  int'(ovf_a[1]),  0);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_quiet_O", int'(o_a[1]), 0);
    end

    // Every expected pulse must have been seen
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("queue_drained[%0d]", k), exp_q[k].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
